// File: rtl/param_universal_sr_if.sv
// Bus bundle for param_universal_sr: op/handshake inputs and register/status outputs.
// The shifter takes the slave side and its driver takes the master side.
interface param_universal_sr_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
);
  logic             en;
  logic [2:0]       sel;
  logic             start;
  logic [SHW-1:0]   shamt;
  logic             left_in;
  logic             right_in;
  logic [WIDTH-1:0] par_in;
  logic [WIDTH-1:0] out;
  logic             so_right;
  logic             so_left;
  logic             busy;
  logic             done;

  modport master (
    output en, sel, start, shamt, left_in, right_in, par_in,
    input  out, so_right, so_left, busy, done
  );

  modport slave (
    input  en, sel, start, shamt, left_in, right_in, par_in,
    output out, so_right, so_left, busy, done
  );
endinterface

// File: rtl/param_universal_sr.sv
// Parametrised universal shift register: single-step ops while idle, plus
// start/busy/done multi-step shifts advancing one bit position per clock.
module param_universal_sr #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input logic                 clk,
  input logic                 clr,
  param_universal_sr_if.slave bus
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHL  = 3'b010,
    OP_LOAD = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ASR  = 3'b110,
    OP_CLR  = 3'b111
  } op_t;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             done_q, done_d;
  op_t              sel_op;

  assign sel_op = op_t'(bus.sel);

  function automatic logic [WIDTH-1:0] step_fn(
    input op_t              op,
    input logic [WIDTH-1:0] cur,
    input logic             li,
    input logic             ri,
    input logic [WIDTH-1:0] par
  );
    logic [WIDTH-1:0] res;
    case (op)
      OP_SHR:  res = {ri, cur[WIDTH-1:1]};
      OP_SHL:  res = {cur[WIDTH-2:0], li};
      OP_LOAD: res = par;
      OP_ROR:  res = {cur[0], cur[WIDTH-1:1]};
      OP_ROL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      OP_ASR:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      OP_CLR:  res = '0;
      default: res = cur;
    endcase
    return res;
  endfunction

  // Only shift-class ops can run multi-cycle; load/clear/hold never launch.
  function automatic logic is_shift(input op_t op);
    return op inside {OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ASR};
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && is_shift(sel_op)) begin
          // Launch edge latches the op and count but leaves out untouched.
          op_d  = sel_op;
          cnt_d = bus.shamt;
          if (bus.shamt != '0) begin
            state_d = S_RUN;
          end else begin
            done_d = 1'b1;
          end
        end else if (bus.en) begin
          out_d = step_fn(sel_op, out_q, bus.left_in, bus.right_in, bus.par_in);
        end
      end
      S_RUN: begin
        out_d = step_fn(op_q, out_q, bus.left_in, bus.right_in, bus.par_in);
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      op_q    <= OP_HOLD;
      out_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.out      = out_q;
  assign bus.so_right = out_q[0];
  assign bus.so_left  = out_q[WIDTH-1];
  assign bus.busy     = (state_q == S_RUN);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_param_universal_sr.sv
// Scoreboard bench for param_universal_sr: the driver pushes per-cycle and
// per-completion expectations from a reference model, a monitor pops and compares.
module tb_param_universal_sr;
  localparam int W  = 8;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  param_universal_sr_if #(.WIDTH(W), .SHW(SW)) bus ();

  param_universal_sr #(.WIDTH(W), .SHW(SW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  typedef struct {
    logic [W-1:0] out;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] done_q[$];
  int           checks = 0;
  int           errors = 0;

  // Reference state: remaining steps of the running operation (0 = idle).
  logic [W-1:0] m_out  = '0;
  int           m_rem  = 0;
  logic [2:0]   m_op   = 3'b000;
  logic         m_done = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] model_step(input logic [2:0] op, input logic [W-1:0] v,
                                              input logic li, input logic ri, input logic [W-1:0] par);
    logic [W-1:0] msb;
    logic [W-1:0] r;
    msb = '0;
    msb[W-1] = 1'b1;
    case (op)
      3'd1:    r = (v >> 1) | (ri ? msb : '0);
      3'd2:    r = (v << 1) | W'(li);
      3'd3:    r = par;
      3'd4:    r = (v >> 1) | (v[0] ? msb : '0);
      3'd5:    r = (v << 1) | W'(v[W-1]);
      3'd6:    r = W'($signed(v) >>> 1);
      3'd7:    r = '0;
      default: r = v;
    endcase
    return r;
  endfunction

  task automatic applyStimulus(input logic c, input logic e, input logic [2:0] s, input logic st,
                               input logic [SW-1:0] sh, input logic li, input logic ri,
                               input logic [W-1:0] par);
    @(negedge clk);
    clr          = c;
    bus.en       = e;
    bus.sel      = s;
    bus.start    = st;
    bus.shamt    = sh;
    bus.left_in  = li;
    bus.right_in = ri;
    bus.par_in   = par;
    if (c) begin
      #1;
      checkOutput("async_clr_out", 32'(bus.out), 32'd0);
      checkOutput("async_clr_busy", 32'(bus.busy), 32'd0);
      checkOutput("async_clr_done", 32'(bus.done), 32'd0);
    end
    if (c) begin
      m_out  = '0;
      m_rem  = 0;
      m_op   = 3'b000;
      m_done = 1'b0;
    end else if (m_rem > 0) begin
      m_out  = model_step(m_op, m_out, li, ri, par);
      m_rem  = m_rem - 1;
      m_done = (m_rem == 0);
    end else begin
      m_done = 1'b0;
      if (st && (s inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6})) begin
        m_op   = s;
        m_rem  = int'(sh);
        m_done = (sh == 0);
      end else if (e) begin
        m_out = model_step(s, m_out, li, ri, par);
      end
    end
    if (m_done) done_q.push_back(m_out);
    exp_q.push_back('{m_out, (m_rem > 0), m_done});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 3'd0, 0, '0, 0, 0, '0);
  endtask

  // Monitor: per-cycle state comparison, plus completion results whenever done is shown.
  initial begin
    exp_t         e;
    logic [W-1:0] d;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("out", 32'(bus.out), 32'(e.out));
        checkOutput("busy", 32'(bus.busy), 32'(e.busy));
        checkOutput("done", 32'(bus.done), 32'(e.done));
        checkOutput("so_right", 32'(bus.so_right), 32'(e.out[0]));
        checkOutput("so_left", 32'(bus.so_left), 32'(e.out[W-1]));
      end
      if (bus.done === 1'b1) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done actual=1 required=0 t=%0t", $time);
        end else begin
          d = done_q.pop_front();
          checkOutput("done_result", 32'(bus.out), 32'(d));
        end
      end
    end
  end

  initial begin
    int waited;
    clr          = 1'b1;
    bus.en       = 1'b0;
    bus.sel      = 3'd0;
    bus.start    = 1'b0;
    bus.shamt    = '0;
    bus.left_in  = 1'b0;
    bus.right_in = 1'b0;
    bus.par_in   = '0;

    applyStimulus(1, 0, 3'd0, 0, '0, 0, 0, '0);
    applyStimulus(0, 1, 3'd3, 0, '0, 0, 0, 8'hA5);
    applyStimulus(0, 1, 3'd1, 0, '0, 0, 1, '0);
    applyStimulus(1, 0, 3'd0, 0, '0, 0, 0, '0);
    applyStimulus(0, 1, 3'd3, 0, '0, 0, 0, 8'hA5);
    applyStimulus(0, 1, 3'd2, 0, '0, 0, 0, '0);

    // Rotate right by 3, then a back-to-back launch on the done cycle.
    applyStimulus(0, 1, 3'd3, 0, '0, 0, 0, 8'hA5);
    applyStimulus(0, 0, 3'd4, 1, 4'd3, 0, 0, '0);
    idle(3);
    applyStimulus(0, 0, 3'd2, 1, 4'd2, 1, 0, '0);
    idle(3);

    // Arithmetic shift right by 4 with ignored requests during busy.
    applyStimulus(0, 1, 3'd3, 0, '0, 0, 0, 8'h90);
    applyStimulus(0, 0, 3'd6, 1, 4'd4, 0, 0, '0);
    applyStimulus(0, 1, 3'd1, 1, 4'd2, 0, 0, '0);
    applyStimulus(0, 1, 3'd3, 0, '0, 0, 0, 8'hFF);
    idle(3);

    // Zero-length launch, then start with load select acting as a plain load.
    applyStimulus(0, 0, 3'd5, 1, 4'd0, 0, 0, '0);
    applyStimulus(0, 1, 3'd3, 1, 4'd7, 0, 0, 8'h5A);
    idle(2);

    // Counts beyond the width: rotate wraps, shift saturates to fill bits.
    applyStimulus(0, 0, 3'd5, 1, 4'd11, 0, 0, '0);
    idle(11);
    applyStimulus(0, 0, 3'd1, 1, 4'd15, 0, 1, '0);
    idle(15);

    // Reset in the middle of a rotate, then a fresh launch.
    applyStimulus(0, 1, 3'd3, 0, '0, 0, 0, 8'h81);
    applyStimulus(0, 0, 3'd5, 1, 4'd5, 0, 0, '0);
    idle(2);
    applyStimulus(1, 0, 3'd0, 0, '0, 0, 0, '0);
    applyStimulus(0, 1, 3'd3, 0, '0, 0, 0, 8'h3C);
    applyStimulus(0, 0, 3'd1, 1, 4'd2, 0, 1, '0);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0), 1'($urandom), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) == 0), SW'($urandom_range(0, 10)),
                    1'($urandom), 1'($urandom), W'($urandom));
    end
    idle(20);

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      #2;
      waited++;
    end
    checkOutput("expect_queue_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("done_queue_empty", 32'(done_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/param_universal_sr.md
Name: param_universal_sr

Overview:
Parametrised universal shift register. It supports hold, logical shift, rotate, arithmetic shift, parallel load and synchronous clear, each as a single-cycle operation. It also runs multi-cycle shift-by-N operations under a start/busy/done handshake, one bit position per clock. It is the general-purpose shifter for datapath and serial-conversion blocks in the lab designs.

Parameters:
- WIDTH, 8: register width in bits; minimum 2.
- SHW, $clog2(WIDTH)+1: width of the shift-amount port, so a shift of WIDTH is representable.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous active-high reset.
- en  input  1  single-cycle operation enable; only honoured when idle.
- sel  input  3  operation select (encoding below).
- start  input  1  launches a multi-cycle shift of shamt steps; only honoured when idle.
- shamt  input  SHW  shift/rotate step count, sampled with start.
- left_in  input  1  serial input entering the LSB on a left shift.
- right_in  input  1  serial input entering the MSB on a right shift.
- par_in  input  WIDTH  parallel load data.
- out  output  WIDTH  register contents.
- so_right  output  1  always equal to out[0] (combinational).
- so_left  output  1  always equal to out[WIDTH-1] (combinational).
- busy  output  1  high while a multi-cycle operation is in progress.
- done  output  1  one-cycle pulse when a multi-cycle operation completes.

Behaviour:
- Reset: clr high asynchronously forces out=0, busy=0, done=0, step counter=0 and the latched op to 000. Reset overrides everything, including mid-operation; the interrupted operation is abandoned with no done pulse.
- sel encoding, one step:
  - 000: hold.
  - 001: shift right, out <= {right_in, out[W-1:1]}.
  - 010: shift left, out <= {out[W-2:0], left_in}.
  - 011: parallel load, out <= par_in.
  - 100: rotate right, {out[0], out[W-1:1]}.
  - 101: rotate left, {out[W-2:0], out[W-1]}.
  - 110: arithmetic shift right, {out[W-1], out[W-1:1]}.
  - 111: synchronous clear, out <= 0.
- Idle priority at each edge: start with a shift-class sel (001, 010, 100, 101, 110) launches a multi-cycle operation. Otherwise, en high performs one step of sel. Otherwise, hold.
- start with sel 000, 011 or 111 is not a launch; the edge follows en as normal.
- Launch edge E0:
  - Latch sel and shamt.
  - out is NOT modified at E0.
  - If shamt>0: busy<=1, counter<=shamt.
  - If shamt==0: busy stays 0 and done<=1 for exactly one cycle.
- While busy:
  - Each edge performs one step of the latched op and decrements the counter.
  - left_in and right_in are sampled live at each step.
  - The edge executing the last step (counter==1) sets busy<=0 and done<=1.
  - Outcome: out changes at edges E1..En, busy is high for n cycles, and done is high for the single cycle after En.
- While busy, en, sel, start, shamt and par_in are ignored. A start on the same cycle that done is high is accepted, since the block is idle then.
- done is otherwise 0 and deasserts after one cycle unconditionally.
- shamt values above WIDTH are legal and execute that many steps. Rotates wrap; shifts saturate to fill bits.
- so_right and so_left reflect the current out, giving the bit about to be shifted out.

Test Plan:
- WIDTH=8. Assert clr asynchronously between edges -> out=00, busy=0, done=0 immediately. Then load (sel=011, en, par_in=A5) -> out=A5 after one edge.
- out=A5. sel=001, en, right_in=1 -> D2. Then sel=010, en, left_in=0 from A5 -> 4A. so_right/so_left track out[0]/out[7] each cycle.
- out=A5. start, sel=100, shamt=3 -> busy high 3 cycles, out steps D2, 69, B4. done pulses one cycle after the last step; final out=B4.
- out=90. start, sel=110, shamt=4 -> final out=F9, busy 4 cycles. start, sel=001 and en pulses during busy are ignored.
- shamt=0 with start, sel=101 -> done pulses at the next cycle, busy never rises, out unchanged. start with sel=011 -> acts as a load when en=1, and no done pulse.
- Launch rotate-left with shamt=5 and assert clr after 2 steps -> out=00, busy=0, no done pulse. A subsequent launch then works normally.
